alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the integer execute path and the address-generation path.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- Drives the ALU operands and 4-bit operation code, registers the ALU result into a one-entry result slot, and returns it to the winning requester with a one-cycle latency and full backpressure.

Parameters:
- DATA_W, 32, operand/result width
- NREQ, 2, number of requesters (legal range 2..4)
- ID_W, 2, width of the owner index (must satisfy 2**ID_W >= NREQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of the result slot
- req_valid_i  in  NREQ  per-requester request valid
- req_ready_o  out  NREQ  per-requester request accepted
- req_a_i  in  NREQ*DATA_W  operand A, requester k in slice k
- req_b_i  in  NREQ*DATA_W  operand B, requester k in slice k
- req_op_i  in  NREQ*4  ALU operation code, requester k in slice k
- alu_a_o  out  DATA_W  operand A to the ALU
- alu_b_o  out  DATA_W  operand B to the ALU
- alu_op_o  out  4  operation code to the ALU
- alu_result_i  in  DATA_W  combinational ALU result
- rsp_valid_o  out  NREQ  one-hot: result ready for requester k
- rsp_ready_i  in  NREQ  per-requester response accepted
- rsp_result_o  out  DATA_W  registered result (shared bus)
- rsp_err_o  out  1  registered flag: request carried an illegal op code

Behaviour:
- Reset, asynchronous on rst_n low:
  - rsp_valid_o=0, rsp_result_o=0, rsp_err_o=0
  - owner=0, rr_ptr=0, slot state EMPTY
  - any pending result is discarded
- Slot FSM, two states:
  - EMPTY -> FULL on an accept.
  - FULL -> EMPTY on a drain with no accept in the same cycle.
  - FULL -> FULL when a drain and an accept happen in the same cycle (back-to-back).
  - Any state -> EMPTY on flush_i.
- Drain condition: FULL && rsp_ready_i[owner].
- Slot free condition: EMPTY, or drain in the same cycle.
- Grant:
  - Combinational pick of the first k with req_valid_i[k]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready_o[k] = grant[k] && slot free && !flush_i.
  - At most one bit of req_ready_o is high in any cycle.
  - req_ready_o may depend on req_valid_i. Requesters must hold valid, operands and op stable until accepted.
- Accept, when req_valid_i[k] && req_ready_o[k] in cycle N:
  - alu_*_o carry requester k's slice during cycle N.
  - At the clock edge, the slot captures alu_result_i, owner=k, and err.
  - rsp_valid_o = one-hot(k) from cycle N+1.
  - rr_ptr becomes (k+1) mod NREQ.
- Idle drive: with no grant, alu_a_o=0, alu_b_o=0, alu_op_o=4'b0010 (ADD).
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SRL, 0110 SLL, 0111 SRA, 1000 EQ, 1010 LUI, 1110 SLT.
- Illegal op code:
  - The request is still accepted.
  - Captured result = 0 and rsp_err_o=1 for that response.
  - The ALU is still driven with the raw code.
- Backpressure:
  - While FULL and rsp_ready_i[owner]=0: rsp_result_o, rsp_err_o and rsp_valid_o hold stable, and all req_ready_o=0.
  - rsp_ready_i of non-owner requesters is ignored.
- flush_i:
  - Has priority over both accept and drain.
  - Slot -> EMPTY, rsp_valid_o=0 from the next cycle.
  - rr_ptr unchanged.
  - rsp_result_o and rsp_err_o keep their stale values but are qualified by rsp_valid_o.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Throughput: one accept per cycle while the owner drains every cycle.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t, a 4-bit enum of the op codes above
  - ALU_OP_W=4
  - function is_legal_op
  - The package is shared with the ALU and the ALU controller.
- One sub-module rr_pick:
  - Parameterised NREQ.
  - Inputs: valid vector and rr_ptr. Outputs: one-hot grant and the encoded index.
  - Purely combinational.

Test Plan:
- Single request: after reset, req0 ADD a=5 b=7 held valid, rsp_ready_i=11 -> accept in cycle 1; rsp_valid_o=01 and rsp_result_o=12 in cycle 2; rr_ptr=1.
- Contention: req0 SUB 10,3 and req1 SLT -1,1 both valid with rr_ptr=0 -> req0 granted first (result 7, rsp_valid_o=01); req1 granted the next cycle (result 1, rsp_valid_o=10); back-to-back with no bubble.
- Backpressure: owner rsp_ready_i low for 3 cycles with req1 pending -> req_ready_o=00 and result stable for 3 cycles; req1 accepted in the same cycle the drain occurs.
- Illegal op: req1 op=4'b1111 -> accepted; response has rsp_err_o=1 and rsp_result_o=0; the next legal response has rsp_err_o=0.
- Flush: flush_i asserted while FULL and req0 valid -> no accept that cycle; rsp_valid_o=00 next cycle; req0 accepted the following cycle.
- Reset mid-operation: rst_n dropped asynchronously while FULL -> rsp_valid_o=00 immediately, rr_ptr=0; after release, req1-only traffic is served correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU op codes and legality helper, shared by the ALU, its controller and
// the requester arbiter.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_LUI = 4'b1010,
        OP_SLT = 4'b1110
    } alu_op_t;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SRL,
            OP_SLL, OP_SRA, OP_EQ, OP_LUI, OP_SLT: is_legal_op = 1'b1;
            default:                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// returned both one-hot and encoded.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        // Walk from the farthest position inwards so the nearest valid wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[(int'(rr_ptr) + i) % NREQ]) begin
                grant = '0;
                grant[(int'(rr_ptr) + i) % NREQ] = 1'b1;
                idx   = ID_W'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NREQ requesters, with a
// one-entry registered result slot returned to the winner under backpressure.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREQ   = 2,
    parameter int ID_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*DATA_W-1:0]     req_a_i,
    input  logic [NREQ*DATA_W-1:0]     req_b_i,
    input  logic [NREQ*ALU_OP_W-1:0]   req_op_i,
    output logic [DATA_W-1:0]          alu_a_o,
    output logic [DATA_W-1:0]          alu_b_o,
    output logic [ALU_OP_W-1:0]        alu_op_o,
    input  logic [DATA_W-1:0]          alu_result_i,
    output logic [NREQ-1:0]            rsp_valid_o,
    input  logic [NREQ-1:0]            rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_result_o,
    output logic                       rsp_err_o
);

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t         state_q, state_d;
    logic [ID_W-1:0]     owner_q, rr_ptr_q, gnt_idx;
    logic [NREQ-1:0]     gnt;
    logic                drain, slot_free, accept;
    logic [ALU_OP_W-1:0] sel_op;

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .valid  (req_valid_i),
        .rr_ptr (rr_ptr_q),
        .grant  (gnt),
        .idx    (gnt_idx)
    );

    // Only the owner's ready can drain the slot; other ready bits are ignored.
    assign drain       = (state_q == FULL) && rsp_ready_i[owner_q];
    assign slot_free   = (state_q == EMPTY) || drain;
    assign req_ready_o = (slot_free && !flush_i) ? gnt : '0;
    assign accept      = |(req_valid_i & req_ready_o);
    assign sel_op      = req_op_i[gnt_idx*ALU_OP_W +: ALU_OP_W];

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = OP_ADD;
        if (|gnt) begin
            alu_a_o  = req_a_i[gnt_idx*DATA_W +: DATA_W];
            alu_b_o  = req_b_i[gnt_idx*DATA_W +: DATA_W];
            alu_op_o = sel_op;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept)           state_d = FULL;
                FULL:    if (drain && !accept) state_d = EMPTY;
                default:                       state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == FULL) rsp_valid_o[owner_q] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            rsp_result_o <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= gnt_idx;
                rr_ptr_q     <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                // Illegal codes still reach the ALU but their result is masked.
                rsp_result_o <= is_legal_op(sel_op) ? alu_result_i : '0;
                rsp_err_o    <= !is_legal_op(sel_op);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: behavioural ALU, response scoreboard
// and cycle-by-cycle checks of handshakes, backpressure, flush and reset.
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int NREQ   = 2;
    localparam int ID_W   = 2;

    typedef struct {
        int          owner;
        logic [31:0] result;
        logic        err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*DATA_W-1:0] req_a_i, req_b_i;
    logic [NREQ*4-1:0]    req_op_i;
    logic [DATA_W-1:0]    alu_a_o, alu_b_o, alu_result_i;
    logic [3:0]           alu_op_o;
    logic [NREQ-1:0]      rsp_valid_o, rsp_ready_i;
    logic [DATA_W-1:0]    rsp_result_o;
    logic                 rsp_err_o;

    logic [31:0] ra [NREQ];
    logic [31:0] rb [NREQ];
    logic [3:0]  rop[NREQ];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    assign req_a_i  = {ra[1], ra[0]};
    assign req_b_i  = {rb[1], rb[0]};
    assign req_op_i = {rop[1], rop[0]};

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_op_i     (req_op_i),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_op_o     (alu_op_o),
        .alu_result_i (alu_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_err_o    (rsp_err_o)
    );

    // Behavioural ALU; unknown codes return garbage the arbiter must mask.
    function automatic logic [31:0] tb_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0110: return a << b[4:0];
            4'b0111: return $unsigned($signed(a) >>> b[4:0]);
            4'b1000: return {31'd0, a == b};
            4'b1010: return {b[19:0], 12'h000};
            4'b1110: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic tb_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                          4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b1110};
    endfunction

    always_comb alu_result_i = tb_alu(alu_op_o, alu_a_o, alu_b_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        rop[k] = op;
        ra[k]  = a;
        rb[k]  = b;
    endtask

    // Sample handshakes mid-cycle, then advance to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (flush_i) begin
            if (|rsp_valid_o && sb.size() > 0) void'(sb.pop_front());
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (rsp_valid_o[k] && rsp_ready_i[k]) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_rsp", rsp_valid_o, 0);
                    end else begin
                        exp_t e = sb.pop_front();
                        chk("sb_owner", k, e.owner);
                        chk("sb_result", rsp_result_o, e.result);
                        chk("sb_err", rsp_err_o, e.err);
                    end
                end
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid_i[k] && req_ready_o[k]) begin
                exp_t e;
                e.owner  = k;
                e.err    = !tb_legal(rop[k]);
                e.result = e.err ? 32'd0 : tb_alu(rop[k], ra[k], rb[k]);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = 2'b11;
        for (int k = 0; k < NREQ; k++) set_req(k, 4'b0000, 32'd0, 32'd0);
        #3;
        chk("reset_rsp_valid", rsp_valid_o, 2'b00);
        chk("reset_rsp_result", rsp_result_o, 32'd0);
        chk("reset_rsp_err", rsp_err_o, 1'b0);
        chk("idle_alu_op", alu_op_o, 4'b0010);
        chk("idle_alu_a", alu_a_o, 32'd0);
        chk("idle_req_ready", req_ready_o, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: ADD 5,7 from req0.
        set_req(0, 4'b0010, 32'd5, 32'd7);
        req_valid_i = 2'b01;
        #1;
        chk("single_ready", req_ready_o, 2'b01);
        chk("single_alu_a", alu_a_o, 32'd5);
        chk("single_alu_b", alu_b_o, 32'd7);
        chk("single_alu_op", alu_op_o, 4'b0010);
        tick();
        req_valid_i = 2'b00;
        #1;
        chk("single_rsp_valid", rsp_valid_o, 2'b01);
        chk("single_rsp_result", rsp_result_o, 32'd12);
        tick();

        // Pointer now at 1: contention goes to req1 first, then req0.
        set_req(0, 4'b0011, 32'd10, 32'd3);
        set_req(1, 4'b1110, 32'hFFFF_FFFF, 32'd1);
        req_valid_i = 2'b11;
        #1;
        chk("ptr1_ready", req_ready_o, 2'b10);
        chk("ptr1_alu_op", alu_op_o, 4'b1110);
        tick();
        req_valid_i = 2'b01;
        #1;
        chk("b2b_rsp_valid", rsp_valid_o, 2'b10);
        chk("b2b_rsp_result", rsp_result_o, 32'd1);
        chk("b2b_ready", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        #1;
        chk("b2b2_rsp_result", rsp_result_o, 32'd7);
        tick();

        // Illegal op from req1: ALU sees raw code, response flagged and zeroed.
        set_req(1, 4'b1111, 32'd3, 32'd4);
        req_valid_i = 2'b10;
        #1;
        chk("illegal_ready", req_ready_o, 2'b10);
        chk("illegal_alu_op", alu_op_o, 4'b1111);
        tick();

        // Contention with pointer 0: req0 first, then req1, no bubble.
        set_req(1, 4'b1110, 32'hFFFF_FFFF, 32'd1);
        req_valid_i = 2'b11;
        #1;
        chk("illegal_rsp_err", rsp_err_o, 1'b1);
        chk("illegal_rsp_result", rsp_result_o, 32'd0);
        chk("ptr0_ready", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b10;
        #1;
        chk("legal_after_err", rsp_err_o, 1'b0);
        chk("contend_result0", rsp_result_o, 32'd7);
        chk("contend_ready1", req_ready_o, 2'b10);
        tick();
        req_valid_i = 2'b00;
        #1;
        chk("contend_rsp_valid1", rsp_valid_o, 2'b10);
        chk("contend_result1", rsp_result_o, 32'd1);
        tick();

        // Backpressure: req0 owns the slot, req1 pending, owner stalls 3 cycles.
        set_req(0, 4'b0100, 32'h0000_FF00, 32'h0000_0FF0);
        req_valid_i = 2'b01;
        #1;
        chk("bp_fill_ready", req_ready_o, 2'b01);
        tick();
        set_req(1, 4'b0110, 32'd1, 32'd4);
        req_valid_i = 2'b10;
        rsp_ready_i = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", req_ready_o, 2'b00);
            chk("bp_rsp_valid", rsp_valid_o, 2'b01);
            chk("bp_rsp_result", rsp_result_o, 32'h0000_F0F0);
            tick();
        end
        rsp_ready_i = 2'b11;
        #1;
        chk("bp_release_ready", req_ready_o, 2'b10);
        tick();
        req_valid_i = 2'b00;
        #1;
        chk("bp_next_result", rsp_result_o, 32'd16);
        tick();

        // Flush while full with req0 valid.
        set_req(0, 4'b0111, 32'h8000_0000, 32'd4);
        req_valid_i = 2'b01;
        tick();
        set_req(0, 4'b0001, 32'd1, 32'd2);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", req_ready_o, 2'b00);
        chk("flush_rsp_valid", rsp_valid_o, 2'b01);
        chk("flush_stale_result", rsp_result_o, 32'hF800_0000);
        tick();
        flush_i = 1'b0;
        #1;
        chk("post_flush_valid", rsp_valid_o, 2'b00);
        chk("post_flush_ready", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        #1;
        chk("post_flush_result", rsp_result_o, 32'd3);
        tick();

        // Asynchronous reset while full.
        #1;
        chk("pre_reset_valid", rsp_valid_o, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", rsp_valid_o, 2'b00);
        chk("async_reset_result", rsp_result_o, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n       = 1'b1;
        rsp_ready_i = 2'b11;
        @(posedge clk);
        #1;

        set_req(0, 4'b1000, 32'd9, 32'd9);
        set_req(1, 4'b1010, 32'd0, 32'h0001_2345);
        req_valid_i = 2'b11;
        #1;
        chk("reset_ptr_ready", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b10;
        #1;
        chk("rst_eq_result", rsp_result_o, 32'd1);
        chk("rst_ready1", req_ready_o, 2'b10);
        tick();
        set_req(1, 4'b0101, 32'h0000_0100, 32'd4);
        #1;
        chk("rst_lui_result", rsp_result_o, 32'h1234_5000);
        chk("rst_req1_only_ready", req_ready_o, 2'b10);
        tick();
        req_valid_i = 2'b00;
        #1;
        chk("rst_srl_valid", rsp_valid_o, 2'b10);
        chk("rst_srl_result", rsp_result_o, 32'h0000_0010);
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
